rr_arbiter_n: RTL and testbench
===============================

RR_ARBITER_N -- requirements
Module: rr_arbiter_n

Interface
REQ-001 SHALL have parameter N, default 3, number of requesters, legal range 2..16.
REQ-002 SHALL have parameter MODE, default 1, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-003 SHALL have parameter MAX_HOLD, default 0, maximum contested hold cycles; 0 = unlimited.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port r  input  N  request vector; bit i = requester i.
REQ-007 SHALL have port g  output  N  registered grant vector; one-hot or all-zero.
REQ-008 SHALL have port g_idx  output  $clog2(N)  binary index of the set g bit; 0 when g is zero.
REQ-009 SHALL have port g_valid  output  1  high exactly when g is non-zero.

Function
REQ-010 SHALL drive g, g_idx and g_valid only from registers; no combinational path from r to any output.
REQ-011 SHALL have one-cycle latency: r sampled at edge k takes effect in g after edge k.
REQ-012 SHALL hold g unchanged while the holder's r bit stays 1 and no preemption (REQ-016) fires.
REQ-013 SHALL move g at the edge where the holder's r bit is 0 to the next winner among current r, with no idle cycle; g becomes 0 if r is all-zero.
REQ-014 In MODE 1, SHALL search from index ptr+1 upward, wrapping N-1 -> 0; ptr = index of the last grant issued.
REQ-015 In MODE 0, SHALL pick the lowest set index; SHALL be non-preemptive, so a higher-priority request never displaces an active holder.
REQ-016 With MAX_HOLD > 0, SHALL count holder cycles while any other r bit is 1; on reaching MAX_HOLD, SHALL move g at that edge to the next winner excluding the holder, per MODE.
REQ-017 SHALL clear the hold counter on every grant change and whenever no other request is pending.
REQ-018 SHALL keep counter width $clog2(MAX_HOLD+1) and saturate it; no wrap.
REQ-019 SHALL leave g at 0 and ptr unchanged when r is all-zero.
REQ-020 SHALL grant a new requester at the same edge the holder drops; the holder is excluded only through its r bit.
REQ-021 SHALL never assert more than one g bit, and SHALL never grant a requester whose r bit was 0 at the sampling edge.

Reset
REQ-022 SHALL, while rst is 0, force g = 0, g_idx = 0, g_valid = 0, hold counter = 0 and ptr = N-1, asynchronously.
REQ-023 SHALL, on rst deassertion, begin arbitration at the first clk edge, with requester 0 first in MODE 1.
REQ-024 SHALL drop any grant in progress when rst asserts mid-operation; no state is retained.

Structure
REQ-025 SHALL take the MODE encodings (ARB_FIXED = 0, ARB_RR = 1) from shared package arb_pkg.
REQ-026 SHALL instantiate one sub-module onehot_to_idx (N-bit one-hot to binary index) to produce g_idx.
REQ-027 SHALL implement the round-robin search as a rotate-then-priority-encode, parametric in N; no per-N case tables.

Verification
REQ-028 SHALL cover the exhaustive test for N=3, MODE=1, MAX_HOLD=0: apply every (before, after) r pair of 8x8 values, 5 cycles each; g matches the golden 64-entry table, e.g. r=111 from reset -> g=001; then r=110 -> g=010.
REQ-029 SHALL cover round-robin rotation for N=4, MODE=1: r held at 1111 with holder toggling its bit off for 1 cycle each time -> g sequence 0001, 0010, 0100, 1000, 0001.
REQ-030 SHALL cover fixed priority for N=4, MODE=0: r=1000 granted (g=1000), then r=1001 -> g stays 1000; r=0001 -> g=0001 next cycle.
REQ-031 SHALL cover preemption for N=3, MODE=1, MAX_HOLD=4: r=011 constant -> g=001 for 4 cycles, then 010 for 4 cycles, alternating.
REQ-032 SHALL cover mid-operation reset: with g=010, assert rst low between edges -> g=000, g_valid=0 immediately; release with r=111 -> g=001 after first edge.
REQ-033 SHALL check the invariants every cycle: g one-hot or zero, g_valid == |g, g_idx consistent with g, (g & ~r_prev) == 0.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared arbitration policy encodings and helpers
// ARB_FIXED / ARB_RR select the MODE of rr_arbiter_n; lsb_idx finds the lowest set bit.
package arb_pkg;
  typedef enum int {ARB_FIXED = 0, ARB_RR = 1} arb_mode_e;
  localparam int ARB_MAX_N = 16;
  // Returns the index of the lowest set bit, or ARB_MAX_N when v is zero.
  function automatic logic [4:0] lsb_idx(input logic [ARB_MAX_N-1:0] v);
    lsb_idx = 5'(ARB_MAX_N);
    for (int i = ARB_MAX_N - 1; i >= 0; i--) if (v[i]) lsb_idx = 5'(i);
  endfunction
endpackage

// File: rtl/rr_arbiter_n_onehot_to_idx.sv
// onehot_to_idx: one-hot (or zero) vector to binary index
// oh: one-hot input; idx: index of the set bit, 0 when oh is zero.
module onehot_to_idx #(
  parameter int N = 3
) (
  input  logic [N-1:0]         oh,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) if (oh[i]) idx = idx | IW'(i);
  end
endmodule

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: registered N-way arbiter, fixed priority or round-robin, optional contested hold limit
// clk: clock; rst: async active-low reset; r: request vector;
// g: registered one-hot grant; g_idx: index of the grant (0 when idle); g_valid: grant present.
module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter int N        = 3,
  parameter int MODE     = ARB_RR,
  parameter int MAX_HOLD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         r,
  output logic [N-1:0]         g,
  output logic [$clog2(N)-1:0] g_idx,
  output logic                 g_valid
);
  localparam int IW = $clog2(N);
  localparam int CW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  logic [IW-1:0] ptr, win;
  logic [CW-1:0] cnt, cnt_nx;
  logic [N-1:0]  g_nx, m, rot;
  logic [IW:0]   base;
  logic [4:0]    j;
  logic          held, others, preempt, chg;
  always_comb begin
    held    = |(g & r);
    others  = |(r & ~g);
    // the current contested cycle is the one that reaches MAX_HOLD
    preempt = MAX_HOLD > 0 && held && others && int'(cnt) + 1 >= MAX_HOLD;
    m       = preempt ? r & ~g : r;
    // rotate so the search origin sits at bit 0, then take the lowest set bit
    base    = MODE == ARB_RR ? {1'b0, ptr} + 1'b1 : '0;
    rot     = N'({m, m} >> base);
    j       = lsb_idx(ARB_MAX_N'(rot));
    win     = IW'((int'(base) + int'(j)) % N);
    g_nx    = held && !preempt ? g : (|m ? {{(N-1){1'b0}}, 1'b1} << win : '0);
    chg     = g_nx != g;
    cnt_nx  = MAX_HOLD == 0 || chg || !others ? '0 : (&cnt ? cnt : cnt + 1'b1);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      g   <= '0;
      ptr <= IW'(N - 1);
      cnt <= '0;
    end else begin
      g   <= g_nx;
      cnt <= cnt_nx;
      if (chg && |g_nx) ptr <= win;
    end
  assign g_valid = |g;
  onehot_to_idx #(.N(N)) u_idx (.oh(g), .idx(g_idx));
endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb_rr_arbiter_n: self-checking bench for rr_arbiter_n across four configurations
module tb_rr_arbiter_n;
  typedef struct {int holder; int last; int hc;} st_t;
  logic clk = 0, rst = 0;
  logic [2:0] r_a = '0, r_d = '0, g_a, g_d;
  logic [3:0] r_b = '0, r_c = '0, g_b, g_c;
  logic [1:0] i_a, i_b, i_c, i_d;
  logic v_a, v_b, v_c, v_d;
  int cmp = 0, bad = 0;
  int nn[4] = '{3, 4, 4, 3};
  int md[4] = '{1, 1, 0, 1};
  int mh[4] = '{0, 0, 0, 4};
  st_t st[4];
  logic [15:0] rp[4], rq[4], ga[4], ia[4];
  logic va[4];
  always #5 clk = ~clk;
  rr_arbiter_n #(.N(3), .MODE(1), .MAX_HOLD(0)) u_a (.clk(clk), .rst(rst), .r(r_a), .g(g_a), .g_idx(i_a), .g_valid(v_a));
  rr_arbiter_n #(.N(4), .MODE(1), .MAX_HOLD(0)) u_b (.clk(clk), .rst(rst), .r(r_b), .g(g_b), .g_idx(i_b), .g_valid(v_b));
  rr_arbiter_n #(.N(4), .MODE(0), .MAX_HOLD(0)) u_c (.clk(clk), .rst(rst), .r(r_c), .g(g_c), .g_idx(i_c), .g_valid(v_c));
  rr_arbiter_n #(.N(3), .MODE(1), .MAX_HOLD(4)) u_d (.clk(clk), .rst(rst), .r(r_d), .g(g_d), .g_idx(i_d), .g_valid(v_d));
  assign rq[0] = 16'(r_a);
  assign rq[1] = 16'(r_b);
  assign rq[2] = 16'(r_c);
  assign rq[3] = 16'(r_d);
  assign ga[0] = 16'(g_a);
  assign ga[1] = 16'(g_b);
  assign ga[2] = 16'(g_c);
  assign ga[3] = 16'(g_d);
  assign ia[0] = 16'(i_a);
  assign ia[1] = 16'(i_b);
  assign ia[2] = 16'(i_c);
  assign ia[3] = 16'(i_d);
  assign va[0] = v_a;
  assign va[1] = v_b;
  assign va[2] = v_c;
  assign va[3] = v_d;

  // Reference model: who holds, who was granted last, how long the holder has been contested.
  function automatic st_t step(int n, int mode, int maxh, st_t s, logic [15:0] q);
    st_t t = s;
    bit others = 0, keep, pre;
    int start, c;
    for (int i = 0; i < n; i++) if (q[i] && i != s.holder) others = 1;
    keep = s.holder >= 0 && q[s.holder];
    t.hc = keep && others ? s.hc + 1 : 0;
    pre = maxh > 0 && keep && t.hc >= maxh;
    if (!keep || pre) begin
      t.holder = -1;
      t.hc = 0;
      start = mode == 1 ? s.last + 1 : 0;
      for (int k = 0; k < n; k++) begin
        c = (start + k) % n;
        if (t.holder < 0 && q[c] && !(pre && c == s.holder)) t.holder = c;
      end
      if (t.holder >= 0) t.last = t.holder;
    end
    return t;
  endfunction

  function automatic logic [15:0] eg(int i);
    return st[i].holder < 0 ? 16'h0 : 16'h1 << st[i].holder;
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < 4; i++) begin
      st[i] <= '{-1, nn[i] - 1, 0};
      rp[i] <= '0;
    end else for (int i = 0; i < 4; i++) begin
      st[i] <= step(nn[i], md[i], mh[i], st[i], rq[i]);
      rp[i] <= rq[i];
    end

  always @(negedge clk) if (rst) for (int i = 0; i < 4; i++) begin
    cmp++;
    if ((ga[i] & (ga[i] - 16'h1)) !== 16'h0 || va[i] !== (ga[i] != 16'h0) ||
        (ga[i] == 16'h0 ? ia[i] !== 16'h0 : ga[i] !== (16'h1 << ia[i])) || (ga[i] & ~rp[i]) !== 16'h0) begin
      bad++;
      $display("FAIL invariant u%0d: g=%b idx=%0d valid=%b r_prev=%b", i, ga[i], ia[i], va[i], rp[i]);
    end
  end

  task automatic do_reset;
    r_a = '0; r_b = '0; r_c = '0; r_d = '0;
    rst = 0;
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset;
    rst = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      cmp++;
      if (ga[i] !== 16'h0 || ia[i] !== 16'h0 || va[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset u%0d: g=%b idx=%0d valid=%b, want all zero", i, ga[i], ia[i], va[i]);
      end
    end
    rst = 1;
  endtask

  task automatic test_exhaustive;
    for (int a = 0; a < 8; a++) for (int b = 0; b < 8; b++) begin
      do_reset();
      for (int c = 0; c < 10; c++) begin
        r_a = c < 5 ? 3'(a) : 3'(b);
        @(negedge clk);
        cmp++;
        if (16'(g_a) !== eg(0)) begin
          bad++;
          $display("FAIL exhaustive %0d->%0d cyc%0d: g=%b want %b", a, b, c, g_a, eg(0));
        end
      end
    end
  endtask

  task automatic test_rotation;
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      r_b = 4'b1111;
      @(negedge clk);
      cmp++;
      if (g_b !== exp_g[k] || 16'(g_b) !== eg(1)) begin
        bad++;
        $display("FAIL rotation step%0d: g=%b want %b", k, g_b, exp_g[k]);
      end
      r_b = ~g_b;
      @(negedge clk);
    end
  endtask

  task automatic test_fixed;
    do_reset();
    r_c = 4'b1000;
    @(negedge clk);
    cmp++;
    if (g_c !== 4'b1000) begin bad++; $display("FAIL fixed_grant: g=%b want 1000", g_c); end
    r_c = 4'b1001;
    repeat (3) begin
      @(negedge clk);
      cmp++;
      if (g_c !== 4'b1000) begin bad++; $display("FAIL fixed_nonpreempt: g=%b want 1000", g_c); end
    end
    r_c = 4'b0001;
    @(negedge clk);
    cmp++;
    if (g_c !== 4'b0001) begin bad++; $display("FAIL fixed_handoff: g=%b want 0001", g_c); end
  endtask

  task automatic test_preempt;
    logic [2:0] e;
    do_reset();
    r_d = 3'b011;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e = (k / 4) % 2 == 0 ? 3'b001 : 3'b010;
      cmp++;
      if (g_d !== e || 16'(g_d) !== eg(3)) begin
        bad++;
        $display("FAIL preempt cyc%0d: g=%b want %b", k, g_d, e);
      end
    end
  endtask

  task automatic test_mid_reset;
    do_reset();
    r_a = 3'b111;
    @(negedge clk);
    cmp++;
    if (g_a !== 3'b001) begin bad++; $display("FAIL first_grant: g=%b want 001", g_a); end
    r_a = 3'b110;
    @(negedge clk);
    cmp++;
    if (g_a !== 3'b010) begin bad++; $display("FAIL second_grant: g=%b want 010", g_a); end
    @(posedge clk);
    #2 rst = 0;
    #1;
    cmp++;
    if (g_a !== 3'b000 || v_a !== 1'b0 || i_a !== 2'd0) begin
      bad++;
      $display("FAIL async_reset: g=%b valid=%b idx=%0d want 000/0/0", g_a, v_a, i_a);
    end
    @(negedge clk);
    r_a = 3'b111;
    rst = 1;
    @(negedge clk);
    cmp++;
    if (g_a !== 3'b001) begin bad++; $display("FAIL reset_release: g=%b want 001", g_a); end
  endtask

  task automatic test_random;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      r_a = r_a ^ (3'($urandom) & 3'($urandom));
      r_b = r_b ^ (4'($urandom) & 4'($urandom));
      r_c = r_c ^ (4'($urandom) & 4'($urandom));
      r_d = r_d ^ (3'($urandom) & 3'($urandom));
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        cmp++;
        if (ga[i] !== eg(i)) begin
          bad++;
          $display("FAIL random u%0d cyc%0d: g=%b want %b", i, k, ga[i], eg(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_rotation();
    test_fixed();
    test_preempt();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
